// File: rtl/multi_cycle_adder.sv
// -----------------------------------------------------------------------------
// multi_cycle_adder
//
// Parametrised multi-cycle adder/subtractor. A WIDTH-bit result is produced one
// CHUNK-bit ripple slice per clock, with the inter-slice carry held in a flop,
// so the combinational path is only CHUNK bits long. WIDTH must be a positive
// multiple of CHUNK; N = WIDTH/CHUNK slices, result after N+1 edges.
//
// Ports
//   clk    in   clock, all state updates on the rising edge
//   rst    in   synchronous active-high reset (priority over start)
//   start  in   request a new operation; honoured only in IDLE or DONE
//   sub    in   0: A+B+CI   1: A-B (A + ~B + 1, CI ignored)
//   A, B   in   WIDTH-bit operands, captured on an accepted start
//   CI     in   carry-in for add mode, captured on an accepted start
//   busy   out  high while slices are being computed
//   done   out  one-cycle pulse when SUM/CO/OFL become valid
//   SUM    out  WIDTH-bit result, stable from done until the next accept
//   CO     out  carry out of the MSB (subtract: 1 = no borrow)
//   OFL    out  two's-complement overflow (carry into MSB xor CO)
// -----------------------------------------------------------------------------
module multi_cycle_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CI,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] SUM,
   output logic             CO,
   output logic             OFL
);

   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [KW-1:0]    k_q, k_d;
   logic             co_q, co_d;
   logic             ofl_q, ofl_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [CHUNK:0]   slice_s;
   logic             msb_cin_s;

   // Slice adder: the current slice always sits in the low CHUNK bits of the
   // operand registers, because they are shifted right after every slice.
   always_comb begin
      slice_s   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
      // Carry into the top bit of the slice; on the last slice this is the
      // carry into the MSB of the full word.
      msb_cin_s = slice_s[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
   end

   // Next-state and datapath next-values for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      k_d     = k_q;
      co_d    = co_q;
      ofl_d   = ofl_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               // Subtraction is folded into an add: invert B, force carry 1.
               a_d     = A;
               b_d     = sub ? ~B : B;
               carry_d = sub ? 1'b1 : CI;
               sum_d   = {WIDTH{1'b0}};
               k_d     = {KW{1'b0}};
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            for (int i = 0; i < N; i++) begin
               if (k_q == KW'(i)) begin
                  sum_d[i*CHUNK +: CHUNK] = slice_s[CHUNK-1:0];
               end else begin
                  sum_d[i*CHUNK +: CHUNK] = sum_q[i*CHUNK +: CHUNK];
               end
            end
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            carry_d = slice_s[CHUNK];
            if (k_q == KW'(N - 1)) begin
               co_d    = slice_s[CHUNK];
               ofl_d   = msb_cin_s ^ slice_s[CHUNK];
               state_d = ST_DONE;
            end else begin
               k_d     = k_q + KW'(1);
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status flags are registered from the state being entered so that
      // busy covers exactly the RUN cycles and done exactly the DONE cycle.
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // All state flops; reset discards any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         sum_q   <= {WIDTH{1'b0}};
         carry_q <= 1'b0;
         k_q     <= {KW{1'b0}};
         co_q    <= 1'b0;
         ofl_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         k_q     <= k_d;
         co_q    <= co_d;
         ofl_q   <= ofl_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign SUM  = sum_q;
   assign CO   = co_q;
   assign OFL  = ofl_q;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_adder
//
// Five adder instances: one 16/4 instance driven with hand-picked operations
// (carry, overflow, subtract, ignored start, back-to-back start, mid-op reset)
// and four instances (16/4, 32/8, 8/8, 12/3) driven with random operations.
// Stimulus pushes expected results into per-instance queues; one monitor
// process pops and compares whenever an instance raises done.
// -----------------------------------------------------------------------------
module tb_multi_cycle_adder;

   typedef struct {
      logic [31:0] sum;
      logic        co;
      logic        ofl;
      int          acc;   // cycle in which start was driven high
      int          lat;   // cycles from start to done
   } exp_t;

   typedef struct {
      int   at;
      logic busy;
      logic rst_state;
   } stat_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   exp_t  exp_q [5][$];
   stat_t stat_q [$];

   logic        r_busy [5];
   logic        r_done [5];
   logic [31:0] r_sum  [5];
   logic        r_co   [5];
   logic        r_ofl  [5];

   logic rst_dir, rst_rand;
   logic end_req = 1'b0;
   logic end_done = 1'b0;
   logic timeout_flag = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: plain integer arithmetic on the operands' unsigned and
   // signed interpretations.
   function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic ci, logic sb);
      exp_t   e;
      longint ua, ub, sa, sbv, span, full, sres;
      span = longint'(1) << w;
      ua   = longint'(a);
      ub   = longint'(b);
      sa   = a[w-1] ? ua - span : ua;
      sbv  = b[w-1] ? ub - span : ub;
      if (!sb) begin
         full = ua + ub + longint'(ci);
         sres = sa + sbv + longint'(ci);
         e.co = (full >= span);
         if (full >= span) full = full - span;
      end else begin
         full = ua - ub;
         sres = sa - sbv;
         e.co = (ua >= ub);
         if (full < 0) full = full + span;
      end
      e.sum = 32'(full);
      e.ofl = (sres > (span / 2 - 1)) || (sres < -(span / 2));
      e.acc = 0;
      e.lat = 0;
      return e;
   endfunction

   function automatic logic [31:0] wmask(int w);
      if (w >= 32) return 32'hFFFF_FFFF;
      else return (32'd1 << w) - 32'd1;
   endfunction

   // ---------------- directed instance (16/4) ----------------
   logic        d_start, d_sub, d_ci;
   logic [15:0] d_a, d_b;
   logic        d_busy, d_done, d_co, d_ofl;
   logic [15:0] d_sum;

   multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) u_dir (
      .clk(clk), .rst(rst_dir), .start(d_start), .sub(d_sub),
      .A(d_a), .B(d_b), .CI(d_ci),
      .busy(d_busy), .done(d_done), .SUM(d_sum), .CO(d_co), .OFL(d_ofl)
   );

   assign r_busy[4] = d_busy;
   assign r_done[4] = d_done;
   assign r_sum[4]  = {16'h0000, d_sum};
   assign r_co[4]   = d_co;
   assign r_ofl[4]  = d_ofl;

   // ---------------- random instances ----------------
   for (genvar g = 0; g < 4; g++) begin : gen_rand
      localparam int W = (g == 0) ? 16 : (g == 1) ? 32 : (g == 2) ? 8 : 12;
      localparam int C = (g == 0) ? 4  : (g == 1) ? 8  : (g == 2) ? 8 : 3;
      localparam int N = W / C;

      logic         start, sub, ci;
      logic [W-1:0] a, b;
      logic         busy, done, co, ofl;
      logic [W-1:0] sum;
      logic         fin = 1'b0;

      multi_cycle_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
         .clk(clk), .rst(rst_rand), .start(start), .sub(sub),
         .A(a), .B(b), .CI(ci),
         .busy(busy), .done(done), .SUM(sum), .CO(co), .OFL(ofl)
      );

      assign r_busy[g] = busy;
      assign r_done[g] = done;
      assign r_sum[g]  = 32'(sum);
      assign r_co[g]   = co;
      assign r_ofl[g]  = ofl;

      initial begin
         logic [31:0] ra, rb, m;
         int          sel;
         exp_t        e;
         start = 1'b0; sub = 1'b0; ci = 1'b0;
         a = '0; b = '0;
         m = wmask(W);
         repeat (6) @(negedge clk);
         for (int op = 0; op < 1000; op++) begin
            ra  = $urandom & m;
            rb  = $urandom & m;
            sel = $urandom_range(0, 7);
            if (sel == 0) ra = m;
            if (sel == 1) rb = m;
            if (sel == 2) ra = 32'd1 << (W - 1);
            if (sel == 3) rb = 32'd0;
            sub   = 1'($urandom_range(0, 1));
            ci    = 1'($urandom_range(0, 1));
            a     = ra[W-1:0];
            b     = rb[W-1:0];
            e     = model(W, ra, rb, ci, sub);
            e.acc = cyc;
            e.lat = N + 1;
            exp_q[g].push_back(e);
            start = 1'b1;
            // Random start/operand noise while the operation runs.
            repeat (N) begin
               @(negedge clk);
               ra    = $urandom;
               rb    = $urandom;
               start = 1'($urandom_range(0, 1));
               sub   = 1'($urandom_range(0, 1));
               ci    = 1'($urandom_range(0, 1));
               a     = ra[W-1:0];
               b     = rb[W-1:0];
            end
            @(negedge clk);
            start = 1'b0;
            if ($urandom_range(0, 1) == 0) repeat (1 + $urandom_range(0, 2)) @(negedge clk);
         end
         repeat (N + 4) @(negedge clk);
         fin = 1'b1;
      end
   end

   // Monitor: scoreboard comparisons on done, timed status checks, end checks.
   always @(negedge clk) begin
      exp_t  e;
      stat_t s;
      for (int i = 0; i < 5; i++) begin
         if (r_done[i]) begin
            checks++;
            if (r_busy[i]) begin
               failures++;
               $display("FAIL busy_done_overlap inst=%0d cyc=%0d got busy=1 want busy=0", i, cyc);
            end
            checks++;
            if (exp_q[i].size() == 0) begin
               failures++;
               $display("FAIL spurious_done inst=%0d cyc=%0d got done=1 want no done", i, cyc);
            end else begin
               e = exp_q[i].pop_front();
               checks++;
               if (r_sum[i] !== e.sum) begin
                  failures++;
                  $display("FAIL sum inst=%0d cyc=%0d got=%h want=%h", i, cyc, r_sum[i], e.sum);
               end
               checks++;
               if (r_co[i] !== e.co) begin
                  failures++;
                  $display("FAIL co inst=%0d cyc=%0d got=%b want=%b", i, cyc, r_co[i], e.co);
               end
               checks++;
               if (r_ofl[i] !== e.ofl) begin
                  failures++;
                  $display("FAIL ofl inst=%0d cyc=%0d got=%b want=%b", i, cyc, r_ofl[i], e.ofl);
               end
               checks++;
               if ((cyc - e.acc) != e.lat) begin
                  failures++;
                  $display("FAIL latency inst=%0d cyc=%0d got=%0d want=%0d", i, cyc, cyc - e.acc, e.lat);
               end
            end
         end
      end
      while (stat_q.size() > 0 && stat_q[0].at <= cyc) begin
         s = stat_q.pop_front();
         checks++;
         if (r_busy[4] !== s.busy) begin
            failures++;
            $display("FAIL dir_busy cyc=%0d got=%b want=%b", cyc, r_busy[4], s.busy);
         end
         if (s.rst_state) begin
            checks++;
            if (r_done[4] !== 1'b0 || r_sum[4] !== 32'd0 || r_co[4] !== 1'b0 || r_ofl[4] !== 1'b0) begin
               failures++;
               $display("FAIL reset_state cyc=%0d got done=%b sum=%h co=%b ofl=%b want all zero",
                        cyc, r_done[4], r_sum[4], r_co[4], r_ofl[4]);
            end
         end
      end
      if (end_req && !end_done) begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
               failures++;
               $display("FAIL missing_done inst=%0d got pending=%0d want 0", i, exp_q[i].size());
            end
         end
         checks++;
         if (stat_q.size() != 0 || timeout_flag) begin
            failures++;
            $display("FAIL run_complete got pending_status=%0d timeout=%b want 0 and 0", stat_q.size(), timeout_flag);
         end
         end_done <= 1'b1;
      end
   end

   function automatic stat_t mk_stat(int at, logic busy, logic rs);
      stat_t s;
      s.at = at;
      s.busy = busy;
      s.rst_state = rs;
      return s;
   endfunction

   // Issue one directed operation at the current negedge; returns at the
   // negedge of its DONE cycle with start low (caller may re-raise it).
   task automatic dir_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sb, input logic [31:0] es, input logic eco,
                         input logic eofl, input bit garbage);
      exp_t e;
      int   c;
      c       = cyc;
      d_a     = a;
      d_b     = b;
      d_ci    = ci;
      d_sub   = sb;
      d_start = 1'b1;
      e.sum = es; e.co = eco; e.ofl = eofl; e.acc = c; e.lat = 5;
      exp_q[4].push_back(e);
      for (int j = 1; j <= 4; j++) stat_q.push_back(mk_stat(c + j, 1'b1, 1'b0));
      stat_q.push_back(mk_stat(c + 5, 1'b0, 1'b0));
      repeat (4) begin
         @(negedge clk);
         d_start = garbage ? 1'b1 : 1'b0;
         d_a     = 16'($urandom);
         d_b     = 16'($urandom);
         d_ci    = ~d_ci;
      end
      @(negedge clk);
      d_start = 1'b0;
   endtask

   // Main sequence: reset, directed operations, then wait for random streams.
   initial begin
      int c;
      rst_dir  = 1'b1;
      rst_rand = 1'b1;
      d_start = 1'b0; d_sub = 1'b0; d_ci = 1'b0; d_a = 16'h0000; d_b = 16'h0000;
      stat_q.push_back(mk_stat(3, 1'b0, 1'b1));
      repeat (3) @(negedge clk);
      rst_dir  = 1'b0;
      rst_rand = 1'b0;
      @(negedge clk);

      dir_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      dir_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      dir_op(16'h1234, 16'h4321, 1'b1, 1'b0, 32'h5556, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      dir_op(16'h0005, 16'h0007, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      dir_op(16'h8000, 16'h0001, 1'b1, 1'b1, 32'h7FFF, 1'b1, 1'b1, 1'b0);
      @(negedge clk);

      // Reset in the second RUN cycle; the operation must vanish.
      c = cyc;
      d_a = 16'hFFFF; d_b = 16'hFFFF; d_ci = 1'b1; d_sub = 1'b0;
      d_start = 1'b1;
      stat_q.push_back(mk_stat(c + 1, 1'b1, 1'b0));
      stat_q.push_back(mk_stat(c + 2, 1'b1, 1'b0));
      stat_q.push_back(mk_stat(c + 3, 1'b0, 1'b1));
      @(negedge clk);
      d_start = 1'b0;
      @(negedge clk);
      rst_dir = 1'b1;
      @(negedge clk);
      rst_dir = 1'b0;
      repeat (8) @(negedge clk);
      dir_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 32'h0100, 1'b0, 1'b0, 1'b0);
      @(negedge clk);

      // Start held during RUN is ignored; start in DONE is accepted.
      dir_op(16'h1111, 16'h2222, 1'b0, 1'b0, 32'h3333, 1'b0, 1'b0, 1'b1);
      dir_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b0);
      repeat (8) @(negedge clk);

      for (int k = 0; k < 80000; k++) begin
         if (gen_rand[0].fin && gen_rand[1].fin && gen_rand[2].fin && gen_rand[3].fin) break;
         @(negedge clk);
      end
      timeout_flag = !(gen_rand[0].fin && gen_rand[1].fin && gen_rand[2].fin && gen_rand[3].fin);
      end_req = 1'b1;
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
